// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types and constants for the memory-mapped UART transmitter
package uart_tx_pkg;

    // Transmitter FSM states; PARITY is only entered when parity is built in
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // STATUS register bit positions
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_PAR   = 4;

    // Default register word addresses
    localparam logic [31:0] DEF_DATA_ADDR   = 32'h1001_0024;
    localparam logic [31:0] DEF_STATUS_ADDR = 32'h1001_0028;

    // Even parity bit for one data byte (XOR of all bits)
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with wrap-bit pointers and push-on-full-with-pop support
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // A pop frees the slot a same-cycle push needs, so full only blocks a lone push
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with FIFO; UART_TX_PARITY_EN adds even parity
module mmio_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] DATA_ADDR    = DEF_DATA_ADDR,
    parameter logic [31:0] STATUS_ADDR  = DEF_STATUS_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        TxD,
    output logic        Busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);

`ifdef UART_TX_PARITY_EN
    localparam logic PAR_PRESENT = 1'b1;
`else
    localparam logic PAR_PRESENT = 1'b0;
`endif

    tx_state_e   r_state;
    tx_state_e   w_state_n;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_n;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_n;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_n;
    logic        r_parity;
    logic        w_parity_n;
    logic        r_txd;
    logic        w_txd_n;
    logic        r_ovf;

    logic        w_hit_data;
    logic        w_hit_status;
    logic        w_push_req;
    logic        w_status_rd;
    logic        w_pop;
    logic        w_ovf_set;
    logic        w_bit_end;
    logic [7:0]  w_fifo_rdata;
    logic        w_full;
    logic        w_empty;
    logic [31:0] w_status;
    logic        w_unused_wdata;

    assign w_hit_data   = (Address == DATA_ADDR);
    assign w_hit_status = (Address == STATUS_ADDR);
    assign Hit          = w_hit_data | w_hit_status;
    assign w_push_req   = MemWrite & w_hit_data;
    assign w_status_rd  = MemRead & w_hit_status;
    assign w_ovf_set    = w_push_req & w_full & ~w_pop;
    assign w_bit_end    = (r_cnt == CW'(CLKS_PER_BIT - 1));
    assign w_unused_wdata = ^WriteData[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push_req),
        .i_wdata (WriteData[7:0]),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Next-state logic: baud counting, bit sequencing and FIFO pops
    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt + CW'(1);
        w_idx_n    = r_idx;
        w_shift_n  = r_shift;
        w_parity_n = r_parity;
        w_pop      = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_n = '0;
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_shift_n  = w_fifo_rdata;
                    w_parity_n = even_parity(w_fifo_rdata);
                    w_state_n  = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_cnt_n   = '0;
                    w_idx_n   = 3'd0;
                    w_state_n = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_cnt_n = '0;
                    if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_n = PARITY;
`else
                        w_state_n = STOP;
`endif
                    end else begin
                        w_shift_n = {1'b0, r_shift[7:1]};
                        w_idx_n   = r_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_end) begin
                    w_cnt_n   = '0;
                    w_state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (w_bit_end) begin
                    w_cnt_n = '0;
                    // Chain straight into the next frame when data is waiting
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_shift_n  = w_fifo_rdata;
                        w_parity_n = even_parity(w_fifo_rdata);
                        w_state_n  = START;
                    end else begin
                        w_state_n = IDLE;
                    end
                end
            end
            default: begin
                w_cnt_n   = '0;
                w_state_n = IDLE;
            end
        endcase
    end

    // Line level for the coming cycle, derived from the state being entered
    always_comb begin
        w_txd_n = 1'b1;
        case (w_state_n)
            START:   w_txd_n = 1'b0;
            DATA:    w_txd_n = w_shift_n[0];
            PARITY:  w_txd_n = w_parity_n;
            default: w_txd_n = 1'b1;
        endcase
    end

    // FSM and datapath registers; TxD is registered so the line never glitches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= 3'd0;
            r_shift  <= 8'd0;
            r_parity <= 1'b0;
            r_txd    <= 1'b1;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_idx    <= w_idx_n;
            r_shift  <= w_shift_n;
            r_parity <= w_parity_n;
            r_txd    <= w_txd_n;
        end
    end

    // Sticky overflow: cleared by a STATUS read unless a new drop happens that cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~w_status_rd);
        end
    end

    // STATUS word assembled from live state
    always_comb begin
        w_status           = '0;
        w_status[ST_FULL]  = w_full;
        w_status[ST_EMPTY] = w_empty;
        w_status[ST_BUSY]  = (r_state != IDLE);
        w_status[ST_OVF]   = r_ovf;
        w_status[ST_PAR]   = PAR_PRESENT;
    end

    assign ReadData = w_status_rd ? w_status : 32'd0;
    assign TxD      = r_txd;
    assign Busy     = (r_state != IDLE) | ~w_empty;

endmodule
